alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, fixed at 4 for this release).
REQ-002 The block SHALL have port i_clk, input, 1, clock; all state updates on rising edge.
REQ-003 The block SHALL have port i_reset, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have ports i_cmd_valid, input, 1, and o_cmd_ready, output, 1: command push handshake.
REQ-005 The block SHALL have ports i_cmd_a, input, 8, operand, and i_cmd_sel, input, 2, opcode (00 add, 01 sub, 10 max, 11 min).
REQ-006 The block SHALL have port i_run, input, 1: issue enable.
REQ-007 The block SHALL have port i_flush, input, 1: discard all queued commands.
REQ-008 The block SHALL have ports o_a, output, 8, and o_sel, output, 2: operand and opcode driven to the downstream registered ALU.
REQ-009 The block SHALL have port o_issue, output, 1: pulse marking the cycle a command's operand appears on o_a.
REQ-010 The block SHALL have port o_retire, output, 1: pulse marking the cycle that command's result is valid on the ALU result register.
REQ-011 The block SHALL have ports o_level, output, 3 (0..4), o_empty, output, 1, o_full, output, 1, and o_retired, output, 8 (retired-command count).

Function
REQ-012 The FIFO SHALL store {a, sel} entries with 2-bit read/write pointers wrapping 3->0 and a 3-bit level.
REQ-013 o_cmd_ready SHALL equal ~o_full (no same-cycle pass-through when full).
REQ-014 A push SHALL occur when i_cmd_valid & o_cmd_ready & ~i_flush; otherwise the FIFO SHALL be unchanged by the command port.
REQ-015 A pop SHALL occur when i_run & ~o_empty & ~i_flush; the popped entry is the oldest.
REQ-016 On a cycle with both push and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-017 A push into an empty FIFO SHALL become poppable no earlier than the following cycle.
REQ-018 i_flush SHALL set level 0, reset both pointers to 0, and override any same-cycle push and pop.
REQ-019 On pop, o_a SHALL register the entry's a at that edge and o_issue SHALL be 1 for the following cycle.
REQ-020 With no pop, o_a SHALL register 8'h00 and o_issue 0, i.e. a NOP (add zero, accumulator unchanged).
REQ-021 o_sel SHALL be a one-cycle-delayed copy of the opcode paired with o_a (NOP opcode 00), because the ALU registers its operand but uses its opcode combinationally.
REQ-022 o_retire SHALL be o_issue delayed by two cycles (issue at edge k -> retire high after edge k+2).
REQ-023 o_retired SHALL increment by 1 on each o_retire cycle, wrapping 255->0.
REQ-024 Commands already issued at a flush SHALL still retire; flush affects only queued entries.
REQ-025 o_empty SHALL be (level==0); o_full SHALL be (level==4); both derived from registered level.

Reset
REQ-026 On i_reset low, regardless of i_clk, pointers, level, o_a, o_sel, o_issue, o_retire, the delay pipeline and o_retired SHALL clear to 0.
REQ-027 During reset, o_empty SHALL be 1, o_full 0, o_cmd_ready 1.
REQ-028 Reset asserted mid-operation SHALL discard queued and in-flight commands; no o_retire follows reset release until a new pop.
REQ-029 FIFO storage contents SHALL need no reset.

Verification
REQ-030 Test 1: reset, i_run=0, push (a=8'h05, sel=00) and (a=8'h03, sel=01) -> o_level=2, o_issue=0, o_a=0.
REQ-031 Test 2: continuing Test 1, raise i_run -> o_a=05 then 03 on consecutive cycles; o_sel=00 then 01 one cycle later; o_retire two cycles after each o_issue; ALU result sequence 05, 02; o_retired=2.
REQ-032 Test 3: push 5 commands with i_run=0 -> fifth not accepted; o_full=1, o_cmd_ready=0, o_level=4.
REQ-033 Test 4: level=2, i_run=1, push every cycle -> level stays 2; order preserved across pointer wrap 3->0.
REQ-034 Test 5: level=3 with one command issued, assert i_flush together with i_cmd_valid -> level 0, push dropped; the in-flight command still gives one o_retire.
REQ-035 Test 6: drop i_reset mid-stream with level=3 -> all outputs 0 immediately, o_empty=1; after release with i_run=1 and no pushes -> o_a=0, o_sel=00, no o_issue.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                            |
// | Description : Small command FIFO that issues {operand, opcode} pairs to a |
// |               downstream registered ALU and tracks their retirement.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_a,
  input  logic [1:0] i_cmd_sel,
  input  logic       i_run,
  input  logic       i_flush,
  output logic [7:0] o_a,
  output logic [1:0] o_sel,
  output logic       o_issue,
  output logic       o_retire,
  output logic [2:0] o_level,
  output logic       o_empty,
  output logic       o_full,
  output logic [7:0] o_retired
);

  localparam int         c_ptr_w    = $clog2(DEPTH);
  localparam logic [2:0] c_full_lvl = 3'(DEPTH);

  logic [9:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [2:0]         r_level;
  logic [7:0]         r_a;
  logic [1:0]         r_sel_q;
  logic [1:0]         r_sel;
  logic               r_issue;
  logic               r_issue_d1;
  logic               r_retire;
  logic [7:0]         r_retired;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [9:0]         w_head;

  assign w_empty = (r_level == 3'd0);
  assign w_full  = (r_level == c_full_lvl);
  assign w_push  = i_cmd_valid & ~w_full & ~i_flush;
  assign w_pop   = i_run & ~w_empty & ~i_flush;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage holds no control meaning, so it is left out of the reset domain.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_a, i_cmd_sel};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= 3'd0;
      r_a        <= 8'h00;
      r_sel_q    <= 2'b00;
      r_sel      <= 2'b00;
      r_issue    <= 1'b0;
      r_issue_d1 <= 1'b0;
      r_retire   <= 1'b0;
      r_retired  <= 8'h00;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= 3'd0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_level <= r_level + 3'd1;
        else if (!w_push && w_pop) r_level <= r_level - 3'd1;
      end
      // Idle cycles send add-zero so the ALU accumulator holds its value.
      r_a        <= w_pop ? w_head[9:2] : 8'h00;
      r_sel_q    <= w_pop ? w_head[1:0] : 2'b00;
      // The ALU registers its operand but decodes the opcode combinationally.
      r_sel      <= r_sel_q;
      r_issue    <= w_pop;
      r_issue_d1 <= r_issue;
      r_retire   <= r_issue_d1;
      r_retired  <= r_retired + {7'd0, r_issue_d1};
    end
  end

  assign o_cmd_ready = ~w_full;
  assign o_a         = r_a;
  assign o_sel       = r_sel;
  assign o_issue     = r_issue;
  assign o_retire    = r_retire;
  assign o_level     = r_level;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_retired   = r_retired;

endmodule
`default_nettype wire
